// File: rtl/pingpong_bank_ctrl_if.sv
// Handshake and address bundle between the ping-pong bank controller and its
// producer/consumer stages. The slave modport is the controller's view.
interface pingpong_bank_ctrl_if #(
    parameter int NUM_BANKS = 2,
    parameter int AW        = 4
);
    localparam int BW = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;

    logic              flush;
    logic              i_write;
    logic              t_read;
    logic [AW-1:0]     i_address0;
    logic [AW-1:0]     t_address0;
    logic [AW-1:0]     t_address1;
    logic [BW+AW-1:0]  i_phys_address0;
    logic [BW+AW-1:0]  t_phys_address0;
    logic [BW+AW-1:0]  t_phys_address1;
    logic [BW-1:0]     i_bank;
    logic [BW-1:0]     t_bank;
    logic              i_full_n;
    logic              t_empty_n;
    logic [BW:0]       count;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output flush, i_write, t_read, i_address0, t_address0, t_address1,
        input  i_phys_address0, t_phys_address0, t_phys_address1,
               i_bank, t_bank, i_full_n, t_empty_n, count,
               err_overflow, err_underflow
    );

    modport slave (
        input  flush, i_write, t_read, i_address0, t_address0, t_address1,
        output i_phys_address0, t_phys_address0, t_phys_address1,
               i_bank, t_bank, i_full_n, t_empty_n, count,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/pingpong_bank_ctrl.sv
// Bank-token tracker for a multi-bank channel memory: writer and reader each own
// a bank, commits/releases move tokens, and local addresses map to physical ones.
module pingpong_bank_ctrl #(
    parameter int NUM_BANKS = 2,
    parameter int AW        = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    pingpong_bank_ctrl_if.slave  bus
);
    localparam int BW = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;

    localparam logic [BW-1:0] PTR_LAST = BW'(NUM_BANKS - 1);
    localparam logic [BW-1:0] PTR_ONE  = BW'(1);
    localparam logic [BW:0]   CNT_FULL = (BW+1)'(NUM_BANKS);
    localparam logic [BW:0]   CNT_ONE  = (BW+1)'(1);

    logic [BW-1:0] r_wptr;
    logic [BW-1:0] r_rptr;
    logic [BW:0]   r_cnt;
    logic          r_full_n;
    logic          r_empty_n;
    logic          r_err_ovf;
    logic          r_err_unf;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [BW-1:0] w_wptr_nxt;
    logic [BW-1:0] w_rptr_nxt;
    logic [BW:0]   w_cnt_nxt;
    logic          w_ovf_nxt;
    logic          w_unf_nxt;

    logic [BW+AW-1:0] w_i_phys0;
    logic [BW+AW-1:0] w_t_phys0;
    logic [BW+AW-1:0] w_t_phys1;

    // Wrap by explicit compare so non-power-of-two bank counts work.
    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign w_wr_ok = bus.i_write & r_full_n;
    assign w_rd_ok = bus.t_read  & r_empty_n;

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cnt_nxt  = r_cnt;
        w_ovf_nxt  = r_err_ovf;
        w_unf_nxt  = r_err_unf;
        if (bus.flush) begin
            w_wptr_nxt = '0;
            w_rptr_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (w_wr_ok) w_wptr_nxt = ptr_inc(r_wptr);
            if (w_rd_ok) w_rptr_nxt = ptr_inc(r_rptr);
            if (w_wr_ok && !w_rd_ok)      w_cnt_nxt = r_cnt + CNT_ONE;
            else if (!w_wr_ok && w_rd_ok) w_cnt_nxt = r_cnt - CNT_ONE;
            if (bus.i_write && !r_full_n)  w_ovf_nxt = 1'b1;
            if (bus.t_read  && !r_empty_n) w_unf_nxt = 1'b1;
        end
    end

    // Flags come from the next count so stages see them one cycle after a pulse.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_full_n  <= 1'b1;
            r_empty_n <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_full_n  <= (w_cnt_nxt != CNT_FULL);
            r_empty_n <= (w_cnt_nxt != '0);
            r_err_ovf <= w_ovf_nxt;
            r_err_unf <= w_unf_nxt;
        end
    end

    assign w_i_phys0 = {r_wptr, bus.i_address0};
    assign w_t_phys0 = {r_rptr, bus.t_address0};
    assign w_t_phys1 = {r_rptr, bus.t_address1};

    assign bus.i_phys_address0 = w_i_phys0;
    assign bus.t_phys_address0 = w_t_phys0;
    assign bus.t_phys_address1 = w_t_phys1;
    assign bus.i_bank          = r_wptr;
    assign bus.t_bank          = r_rptr;
    assign bus.i_full_n        = r_full_n;
    assign bus.t_empty_n       = r_empty_n;
    assign bus.count           = r_cnt;
    assign bus.err_overflow    = r_err_ovf;
    assign bus.err_underflow   = r_err_unf;
endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl: a 2-bank and a 3-bank instance driven
// through short scenarios with hand-computed expectations.
module tb_pingpong_bank_ctrl;
    logic ap_clk;
    logic ap_rst_n;
    int   n_checks;
    int   n_errors;

    pingpong_bank_ctrl_if #(.NUM_BANKS(2), .AW(4)) b2 ();
    pingpong_bank_ctrl_if #(.NUM_BANKS(3), .AW(4)) b3 ();

    pingpong_bank_ctrl #(.NUM_BANKS(2), .AW(4)) dut2 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (b2)
    );

    pingpong_bank_ctrl #(.NUM_BANKS(3), .AW(4)) dut3 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (b3)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (b2.i_full_n !== 1'b1) begin n_errors++; $display("FAIL rst_full_n: got %0b want 1", b2.i_full_n); end
        n_checks++; if (b2.t_empty_n !== 1'b0) begin n_errors++; $display("FAIL rst_empty_n: got %0b want 0", b2.t_empty_n); end
        ap_rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (b2.count !== 2'd0) begin n_errors++; $display("FAIL idle_count: got %0d want 0", b2.count); end
        n_checks++; if (b2.i_bank !== 1'b0 || b2.t_bank !== 1'b0) begin n_errors++; $display("FAIL idle_banks: got %0d/%0d want 0/0", b2.i_bank, b2.t_bank); end
        n_checks++; if (b2.err_overflow !== 1'b0 || b2.err_underflow !== 1'b0) begin n_errors++; $display("FAIL idle_errs: got %0b/%0b want 0/0", b2.err_overflow, b2.err_underflow); end
        n_checks++; if (b2.i_full_n !== 1'b1 || b2.t_empty_n !== 1'b0) begin n_errors++; $display("FAIL idle_flags: got %0b/%0b want 1/0", b2.i_full_n, b2.t_empty_n); end
    endtask

    task automatic test_commit();
        tick();
        tick();
        b2.i_address0 = 4'd3;
        b2.t_address0 = 4'd7;
        b2.i_write = 1'b1;
        tick();
        b2.i_write = 1'b0;
        n_checks++; if (b2.count !== 2'd1) begin n_errors++; $display("FAIL commit_count: got %0d want 1", b2.count); end
        n_checks++; if (b2.i_bank !== 1'b1 || b2.t_bank !== 1'b0) begin n_errors++; $display("FAIL commit_banks: got %0d/%0d want 1/0", b2.i_bank, b2.t_bank); end
        n_checks++; if (b2.t_empty_n !== 1'b1 || b2.i_full_n !== 1'b1) begin n_errors++; $display("FAIL commit_flags: got %0b/%0b want 1/1", b2.t_empty_n, b2.i_full_n); end
        n_checks++; if (b2.i_phys_address0 !== 5'h13) begin n_errors++; $display("FAIL commit_iphys: got %0h want 13", b2.i_phys_address0); end
        n_checks++; if (b2.t_phys_address0 !== 5'h07) begin n_errors++; $display("FAIL commit_tphys0: got %0h want 07", b2.t_phys_address0); end
    endtask

    task automatic test_fill_overflow();
        b2.i_write = 1'b1;
        tick();
        n_checks++; if (b2.count !== 2'd2) begin n_errors++; $display("FAIL fill_count: got %0d want 2", b2.count); end
        n_checks++; if (b2.i_full_n !== 1'b0) begin n_errors++; $display("FAIL fill_full_n: got %0b want 0", b2.i_full_n); end
        n_checks++; if (b2.i_bank !== 1'b0) begin n_errors++; $display("FAIL fill_wrap: got %0d want 0", b2.i_bank); end
        n_checks++; if (b2.err_overflow !== 1'b0) begin n_errors++; $display("FAIL fill_no_ovf: got %0b want 0", b2.err_overflow); end
        tick();
        b2.i_write = 1'b0;
        n_checks++; if (b2.err_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %0b want 1", b2.err_overflow); end
        n_checks++; if (b2.count !== 2'd2 || b2.i_bank !== 1'b0) begin n_errors++; $display("FAIL ovf_state: got cnt %0d bank %0d want 2/0", b2.count, b2.i_bank); end
    endtask

    task automatic test_full_simultaneous();
        do_reset();
        b2.i_write = 1'b1;
        tick();
        tick();
        n_checks++; if (b2.count !== 2'd2) begin n_errors++; $display("FAIL sim_prefill: got %0d want 2", b2.count); end
        b2.t_read = 1'b1;
        b2.t_address1 = 4'd2;
        tick();
        b2.i_write = 1'b0;
        b2.t_read = 1'b0;
        n_checks++; if (b2.count !== 2'd1) begin n_errors++; $display("FAIL sim_count: got %0d want 1", b2.count); end
        n_checks++; if (b2.t_bank !== 1'b1 || b2.i_bank !== 1'b0) begin n_errors++; $display("FAIL sim_banks: got %0d/%0d want 0/1", b2.i_bank, b2.t_bank); end
        n_checks++; if (b2.i_full_n !== 1'b1) begin n_errors++; $display("FAIL sim_full_n: got %0b want 1", b2.i_full_n); end
        n_checks++; if (b2.err_overflow !== 1'b1) begin n_errors++; $display("FAIL sim_ovf: got %0b want 1", b2.err_overflow); end
        n_checks++; if (b2.t_phys_address1 !== 5'h12) begin n_errors++; $display("FAIL sim_tphys1: got %0h want 12", b2.t_phys_address1); end
    endtask

    task automatic test_back_to_back();
        b2.i_write = 1'b1;
        b2.t_read = 1'b1;
        tick();
        b2.i_write = 1'b0;
        b2.t_read = 1'b0;
        n_checks++; if (b2.count !== 2'd1) begin n_errors++; $display("FAIL b2b_count: got %0d want 1", b2.count); end
        n_checks++; if (b2.i_bank !== 1'b1 || b2.t_bank !== 1'b0) begin n_errors++; $display("FAIL b2b_banks: got %0d/%0d want 1/0", b2.i_bank, b2.t_bank); end
        n_checks++; if (b2.err_underflow !== 1'b0) begin n_errors++; $display("FAIL b2b_unf: got %0b want 0", b2.err_underflow); end
    endtask

    task automatic test_wrap3();
        logic [1:0] exp;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp = 2'(k % 3);
            n_checks++; if (b3.i_bank !== exp) begin n_errors++; $display("FAIL wrap3_ibank%0d: got %0d want %0d", k, b3.i_bank, exp); end
            if (k > 0) begin
                exp = 2'((k - 1) % 3);
                n_checks++; if (b3.t_bank !== exp) begin n_errors++; $display("FAIL wrap3_tbank%0d: got %0d want %0d", k - 1, b3.t_bank, exp); end
            end
            b3.i_write = 1'b1;
            b3.t_read = (k > 0);
            tick();
        end
        b3.i_write = 1'b0;
        b3.t_read = 1'b0;
        n_checks++; if (b3.t_bank !== 2'd1 || b3.count !== 3'd1) begin n_errors++; $display("FAIL wrap3_tbank4: got bank %0d cnt %0d want 1/1", b3.t_bank, b3.count); end
        b3.t_read = 1'b1;
        tick();
        b3.t_read = 1'b0;
        n_checks++; if (b3.count !== 3'd0 || b3.t_empty_n !== 1'b0) begin n_errors++; $display("FAIL wrap3_drain: got cnt %0d empty_n %0b want 0/0", b3.count, b3.t_empty_n); end
        n_checks++; if (b3.i_bank !== 2'd2 || b3.t_bank !== 2'd2) begin n_errors++; $display("FAIL wrap3_final: got %0d/%0d want 2/2", b3.i_bank, b3.t_bank); end
    endtask

    task automatic test_underflow();
        do_reset();
        b2.t_read = 1'b1;
        tick();
        b2.t_read = 1'b0;
        n_checks++; if (b2.err_underflow !== 1'b1) begin n_errors++; $display("FAIL unf_flag: got %0b want 1", b2.err_underflow); end
        n_checks++; if (b2.t_bank !== 1'b0 || b2.count !== 2'd0) begin n_errors++; $display("FAIL unf_state: got bank %0d cnt %0d want 0/0", b2.t_bank, b2.count); end
        n_checks++; if (b2.t_empty_n !== 1'b0 || b2.err_overflow !== 1'b0) begin n_errors++; $display("FAIL unf_flags: got %0b/%0b want 0/0", b2.t_empty_n, b2.err_overflow); end
    endtask

    task automatic test_flush();
        b2.i_write = 1'b1;
        tick();
        tick();
        tick();
        n_checks++; if (b2.count !== 2'd2 || b2.err_overflow !== 1'b1) begin n_errors++; $display("FAIL flush_pre: got cnt %0d ovf %0b want 2/1", b2.count, b2.err_overflow); end
        b2.flush = 1'b1;
        tick();
        b2.flush = 1'b0;
        b2.i_write = 1'b0;
        n_checks++; if (b2.count !== 2'd0) begin n_errors++; $display("FAIL flush_count: got %0d want 0", b2.count); end
        n_checks++; if (b2.i_bank !== 1'b0 || b2.t_bank !== 1'b0) begin n_errors++; $display("FAIL flush_banks: got %0d/%0d want 0/0", b2.i_bank, b2.t_bank); end
        n_checks++; if (b2.i_full_n !== 1'b1 || b2.t_empty_n !== 1'b0) begin n_errors++; $display("FAIL flush_flags: got %0b/%0b want 1/0", b2.i_full_n, b2.t_empty_n); end
        n_checks++; if (b2.err_overflow !== 1'b1 || b2.err_underflow !== 1'b1) begin n_errors++; $display("FAIL flush_errs_held: got %0b/%0b want 1/1", b2.err_overflow, b2.err_underflow); end
    endtask

    task automatic test_reset_midop();
        b2.i_write = 1'b1;
        tick();
        n_checks++; if (b2.count !== 2'd1) begin n_errors++; $display("FAIL midop_pre: got %0d want 1", b2.count); end
        ap_rst_n = 1'b0;
        b2.t_read = 1'b1;
        tick();
        ap_rst_n = 1'b1;
        b2.i_write = 1'b0;
        b2.t_read = 1'b0;
        n_checks++; if (b2.count !== 2'd0 || b2.i_bank !== 1'b0 || b2.t_bank !== 1'b0) begin n_errors++; $display("FAIL midop_state: got cnt %0d banks %0d/%0d want 0/0/0", b2.count, b2.i_bank, b2.t_bank); end
        n_checks++; if (b2.i_full_n !== 1'b1 || b2.t_empty_n !== 1'b0) begin n_errors++; $display("FAIL midop_flags: got %0b/%0b want 1/0", b2.i_full_n, b2.t_empty_n); end
        n_checks++; if (b2.err_overflow !== 1'b0 || b2.err_underflow !== 1'b0) begin n_errors++; $display("FAIL midop_errs: got %0b/%0b want 0/0", b2.err_overflow, b2.err_underflow); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ap_rst_n = 1'b0;
        b2.flush = 1'b0; b2.i_write = 1'b0; b2.t_read = 1'b0;
        b2.i_address0 = '0; b2.t_address0 = '0; b2.t_address1 = '0;
        b3.flush = 1'b0; b3.i_write = 1'b0; b3.t_read = 1'b0;
        b3.i_address0 = '0; b3.t_address0 = '0; b3.t_address1 = '0;

        test_reset();
        test_commit();
        test_fill_overflow();
        test_full_simultaneous();
        test_back_to_back();
        test_wrap3();
        test_underflow();
        test_flush();
        test_reset_midop();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pingpong_bank_ctrl.md
Name: pingpong_bank_ctrl

Overview:
- Control and arbitration core for a multi-bank (ping-pong) channel memory between two dataflow stages.
- The producer stage owns one bank for writes while the consumer stage owns a different, committed bank for reads.
- Tracks bank ownership tokens and generates the i_full_n / t_empty_n handshake flags that drive the stages' ap_continue / ap_start.
- Maps each side's local addresses into physical bank addresses for a shared storage array.

Parameters:
- NUM_BANKS, 2, number of banks; legal range 2..8; need not be a power of two.
- AW, 4, local (per-bank) address width.
- BW, derived as clog2(NUM_BANKS) with minimum 1; bank index width; not user-settable.

Ports:
- ap_clk  in  1  clock; all state updates on its rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of pointers and count; error flags are kept.
- i_write  in  1  producer commit pulse (producer ap_done); releases the current write bank to the reader side.
- t_read  in  1  consumer release pulse (consumer ap_ready); returns the current read bank to the writer side.
- i_address0  in  AW  producer local address, port 0.
- t_address0  in  AW  consumer local address, port 0.
- t_address1  in  AW  consumer local address, port 1.
- i_phys_address0  out  BW+AW  physical address {i_bank, i_address0}.
- t_phys_address0  out  BW+AW  physical address {t_bank, t_address0}.
- t_phys_address1  out  BW+AW  physical address {t_bank, t_address1}.
- i_bank  out  BW  current write bank index.
- t_bank  out  BW  current read bank index.
- i_full_n  out  1  high when at least one bank is free for writing.
- t_empty_n  out  1  high when at least one committed bank is waiting to be read.
- count  out  BW+1  number of committed, unread banks (0..NUM_BANKS).
- err_overflow  out  1  sticky flag: i_write arrived while i_full_n was 0.
- err_underflow  out  1  sticky flag: t_read arrived while t_empty_n was 0.

Behaviour:
- State registers: wptr (BW bits), rptr (BW bits), cnt (BW+1 bits), err_overflow, err_underflow.
- Reset (ap_rst_n=0 at a clock edge): wptr=0, rptr=0, cnt=0, i_full_n=1, t_empty_n=0, i_bank=0, t_bank=0, both error flags=0.
  - Reset applied mid-operation discards all tokens; there is no partial state.
  - Reset has priority over flush and over all pulses.
- Flush (ap_rst_n=1, flush=1): wptr, rptr and cnt go to 0. Error flags hold. i_write and t_read are ignored in that cycle.
- Qualified events use the registered flags of the current cycle:
  - wr_ok = i_write & i_full_n
  - rd_ok = t_read & t_empty_n
- On wr_ok: wptr advances; it wraps NUM_BANKS-1 -> 0 (explicit compare, not modulo 2^BW).
- On rd_ok: rptr advances with the same wrap rule.
- Count update:
  - wr_ok only: cnt+1.
  - rd_ok only: cnt-1.
  - both: cnt unchanged, both pointers advance.
  - A write into a full channel is never accepted, even if a read occurs in the same cycle. The freed bank becomes writable the next cycle.
- Flags, all registered:
  - i_full_n = (cnt != NUM_BANKS)
  - t_empty_n = (cnt != 0)
  - Both are derived from the next-state cnt, so they change 1 cycle after the qualifying pulse.
- Error flags:
  - i_write with i_full_n=0: err_overflow sets 1 cycle later; no other state changes.
  - t_read with t_empty_n=0: err_underflow sets 1 cycle later; no other state changes.
  - Both flags clear only on reset.
- Pulse width: i_write and t_read are level-sampled every cycle. A pulse held for k cycles counts as k events.
- Outputs i_bank=wptr and t_bank=rptr, registered.
- Physical address outputs are combinational concatenations of the registered bank index and the input address, with zero added latency.
- Ownership invariant: when 0 < cnt < NUM_BANKS, i_bank != t_bank.
  - The writer never holds the bank being read while that bank is committed.
  - When cnt=0, i_bank==t_bank and the consumer must not be reading (t_empty_n=0).
- Handshake latency: a commit on cycle n gives t_empty_n=1 on cycle n+1, so the consumer may start at n+1.

Test Plan:
- Reset then idle (NUM_BANKS=2): i_full_n=1, t_empty_n=0, count=0, i_bank=0, t_bank=0, both error flags 0.
- i_write pulse at cycle 5 -> cycle 6: count=1, i_bank=1, t_bank=0, t_empty_n=1, i_full_n=1. i_address0=3 -> i_phys_address0=5'h13.
- Two i_write pulses with no reads -> count=2, i_full_n=0, i_bank=0 (wrapped). A third i_write -> err_overflow=1, count stays 2.
- count=2 with i_write and t_read in the same cycle -> write rejected, err_overflow=1. Next cycle: count=1, t_bank=1, i_full_n=1.
- count=1 with i_write and t_read in the same cycle -> count stays 1, both pointers advance. NUM_BANKS=3 run of 5 writes interleaved with reads -> wrap sequence 0,1,2,0,1 on both sides.
- t_read at count=0 -> err_underflow=1, rptr unchanged. Flush at count=2 -> count=0, pointers 0, err flags held. ap_rst_n=0 -> all outputs at reset values.
